// File: rtl/multi_port_axi_bridge_pkg.sv
// rtl/multi_port_axi_bridge_pkg.sv - bridge FSM encoding and single-beat AXI attributes
package multi_port_axi_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_DATA = 3'd2,
    WR_REQ  = 3'd3,
    WR_RESP = 3'd4,
    DONE    = 3'd5
  } bridge_state_e;

  localparam logic [7:0] LEN_1      = 8'd0;
  localparam logic [2:0] SIZE_4B    = 3'b010;
  localparam logic [1:0] BURST_INCR = 2'b01;

  // Port index width; a single port still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/multi_port_axi_bridge_rr_arbiter.sv
// rtl/multi_port_axi_bridge_rr_arbiter.sv - combinational round-robin pick starting at ptr
module rr_arbiter
  import multi_port_axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  localparam int IDX_W = idx_width(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic [IDX_W-1:0]     ptr_i,
  output logic                 gnt_valid_o,
  output logic [IDX_W-1:0]     gnt_idx_o
);

  logic [2*NUM_PORTS-1:0] req_dbl;
  logic [NUM_PORTS-1:0]   req_rot;

  // Rotate so bit 0 is the port at ptr; the first set bit upward wins.
  assign req_dbl = {req_i, req_i} >> ptr_i;
  assign req_rot = req_dbl[NUM_PORTS-1:0];

  always_comb begin
    gnt_valid_o = 1'b0;
    gnt_idx_o   = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!gnt_valid_o && req_rot[i]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = IDX_W'((int'(ptr_i) + i) % NUM_PORTS);
      end
    end
  end

endmodule

// File: rtl/multi_port_axi_bridge.sv
// rtl/multi_port_axi_bridge.sv - N SRAM-like ports onto one single-beat AXI master
module multi_port_axi_bridge
  import multi_port_axi_bridge_pkg::*;
#(
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 4
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic [NUM_PORTS-1:0]        port_req,
  input  logic [4*NUM_PORTS-1:0]      port_wen,
  input  logic [ADDR_W*NUM_PORTS-1:0] port_addr,
  input  logic [32*NUM_PORTS-1:0]     port_wdata,
  output logic [NUM_PORTS-1:0]        port_done,
  output logic [31:0]                 port_rdata,
  output logic [ID_W-1:0]             arid,
  output logic [ADDR_W-1:0]           araddr,
  output logic                        arvalid,
  input  logic                        arready,
  input  logic [31:0]                 rdata,
  input  logic                        rvalid,
  output logic                        rready,
  output logic [ID_W-1:0]             awid,
  output logic [ADDR_W-1:0]           awaddr,
  output logic                        awvalid,
  input  logic                        awready,
  output logic [31:0]                 wdata,
  output logic [3:0]                  wstrb,
  output logic                        wvalid,
  output logic                        wlast,
  input  logic                        wready,
  input  logic                        bvalid,
  output logic                        bready,
  output logic [7:0]                  arlen,
  output logic [2:0]                  arsize,
  output logic [1:0]                  arburst,
  output logic [7:0]                  awlen,
  output logic [2:0]                  awsize,
  output logic [1:0]                  awburst
);

  localparam int IDX_W = idx_width(NUM_PORTS);

  bridge_state_e     state_q, state_d;
  logic [IDX_W-1:0]  grant_q, grant_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wen_q, wen_d;
  logic [31:0]       rd_buf_q, rd_buf_d;
  logic              aw_done_q, aw_done_d;
  logic              w_done_q, w_done_d;

  logic              gnt_valid;
  logic [IDX_W-1:0]  gnt_idx;

  rr_arbiter #(.NUM_PORTS(NUM_PORTS)) u_rr_arbiter (
    .req_i       (port_req),
    .ptr_i       (rr_ptr_q),
    .gnt_valid_o (gnt_valid),
    .gnt_idx_o   (gnt_idx)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wen_q     <= '0;
      rd_buf_q  <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      rr_ptr_q  <= rr_ptr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      wen_q     <= wen_d;
      rd_buf_q  <= rd_buf_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    rr_ptr_d  = rr_ptr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    wen_d     = wen_q;
    rd_buf_d  = rd_buf_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    arvalid   = 1'b0;
    rready    = 1'b0;
    awvalid   = 1'b0;
    wvalid    = 1'b0;
    bready    = 1'b0;
    port_done = '0;

    unique case (state_q)
      IDLE: begin
        if (gnt_valid) begin
          grant_d   = gnt_idx;
          addr_d    = port_addr[gnt_idx*ADDR_W +: ADDR_W];
          wdata_d   = port_wdata[gnt_idx*32 +: 32];
          wen_d     = port_wen[gnt_idx*4 +: 4];
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = (wen_d != 4'h0) ? WR_REQ : RD_ADDR;
        end
      end
      RD_ADDR: begin
        arvalid = 1'b1;
        if (arready) state_d = RD_DATA;
      end
      RD_DATA: begin
        rready = 1'b1;
        if (rvalid) begin
          rd_buf_d = rdata;
          state_d  = DONE;
        end
      end
      WR_REQ: begin
        // AW and W complete independently, possibly in the same cycle.
        awvalid   = !aw_done_q;
        wvalid    = !w_done_q;
        aw_done_d = aw_done_q | (awvalid & awready);
        w_done_d  = w_done_q | (wvalid & wready);
        if (aw_done_d && w_done_d) state_d = WR_RESP;
      end
      WR_RESP: begin
        bready = 1'b1;
        if (bvalid) state_d = DONE;
      end
      DONE: begin
        port_done = NUM_PORTS'(1) << grant_q;
        rr_ptr_d  = (grant_q == IDX_W'(NUM_PORTS - 1)) ? '0 : grant_q + 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign port_rdata = rd_buf_q;
  assign arid       = ID_W'(grant_q);
  assign awid       = ID_W'(grant_q);
  assign araddr     = addr_q;
  assign awaddr     = addr_q;
  assign wdata      = wdata_q;
  assign wstrb      = wen_q;
  assign wlast      = wvalid;
  assign arlen      = LEN_1;
  assign awlen      = LEN_1;
  assign arsize     = SIZE_4B;
  assign awsize     = SIZE_4B;
  assign arburst    = BURST_INCR;
  assign awburst    = BURST_INCR;

endmodule

// File: tb/tb_multi_port_axi_bridge.sv
// tb/tb_multi_port_axi_bridge.sv - directed and random transactions against a transaction-level model
module tb_multi_port_axi_bridge;

  localparam int NP = 2;
  localparam int AW = 32;
  localparam int IW = 4;

  logic             clk = 1'b0;
  logic             resetn;
  logic [NP-1:0]    port_req;
  logic [4*NP-1:0]  port_wen;
  logic [AW*NP-1:0] port_addr;
  logic [32*NP-1:0] port_wdata;
  logic [NP-1:0]    port_done;
  logic [31:0]      port_rdata;
  logic [IW-1:0]    arid, awid;
  logic [AW-1:0]    araddr, awaddr;
  logic             arvalid, arready, rvalid, rready;
  logic [31:0]      rdata, wdata;
  logic             awvalid, awready, wvalid, wready, wlast, bvalid, bready;
  logic [3:0]       wstrb;
  logic [7:0]       arlen, awlen;
  logic [2:0]       arsize, awsize;
  logic [1:0]       arburst, awburst;

  always #5 clk = ~clk;

  multi_port_axi_bridge #(.NUM_PORTS(NP), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk(clk), .resetn(resetn),
    .port_req(port_req), .port_wen(port_wen), .port_addr(port_addr), .port_wdata(port_wdata),
    .port_done(port_done), .port_rdata(port_rdata),
    .arid(arid), .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wlast(wlast), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .awlen(awlen), .awsize(awsize), .awburst(awburst)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Slave knobs: each ready/valid rises after its partner has waited this many cycles.
  int          ar_delay = 0, r_delay = 0, aw_delay = 0, w_delay = 0, b_delay = 0;
  logic [31:0] r_value = '0;
  bit          spurious = 1'b0;

  initial begin
    int ar_cnt, r_cnt, aw_cnt, w_cnt, b_cnt;
    arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
    ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        arready = 0; rvalid = 0; rdata = 0; awready = 0; wready = 0; bvalid = 0;
        ar_cnt = 0; r_cnt = 0; aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else if (spurious) begin
        arready = 0; awready = 0; wready = 0;
        rvalid = 1; bvalid = 1; rdata = 32'hBAD0BAD0;
      end else begin
        if (arvalid) begin arready = (ar_cnt == ar_delay); ar_cnt++; end
        else begin arready = 0; ar_cnt = 0; end
        if (rready) begin rvalid = (r_cnt == r_delay); rdata = rvalid ? r_value : 32'h0; r_cnt++; end
        else begin rvalid = 0; rdata = 0; r_cnt = 0; end
        if (awvalid) begin awready = (aw_cnt == aw_delay); aw_cnt++; end
        else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt == w_delay); w_cnt++; end
        else begin wready = 0; w_cnt = 0; end
        if (bready) begin bvalid = (b_cnt == b_delay); b_cnt++; end
        else begin bvalid = 0; b_cnt = 0; end
      end
    end
  end

  // Per-transaction observations, cleared once the done pulse has been seen.
  int          arv_cycles, ar_hs, aw_hs, w_hs;
  logic [AW-1:0] obs_araddr, obs_awaddr;
  logic [IW-1:0] obs_arid, obs_awid;
  logic [31:0] obs_wdata;
  logic [3:0]  obs_wstrb;
  logic        obs_wlast;
  bit          hold_ar, hold_aw, hold_w;

  always @(posedge clk) begin
    if (!resetn || port_done != '0) begin
      arv_cycles <= 0; ar_hs <= 0; aw_hs <= 0; w_hs <= 0;
      hold_ar <= 0; hold_aw <= 0; hold_w <= 0;
    end else begin
      if (arvalid) arv_cycles <= arv_cycles + 1;
      if (arvalid && arready) begin ar_hs <= ar_hs + 1; obs_araddr <= araddr; obs_arid <= arid; end
      if (awvalid && awready) begin aw_hs <= aw_hs + 1; obs_awaddr <= awaddr; obs_awid <= awid; end
      if (wvalid && wready) begin
        w_hs <= w_hs + 1; obs_wdata <= wdata; obs_wstrb <= wstrb; obs_wlast <= wlast;
      end
      if (bready) begin
        check("bready_after_aw_hs", aw_hs, 1);
        check("bready_after_w_hs", w_hs, 1);
      end
      if (hold_ar) check("arvalid_held", arvalid, 1'b1);
      if (hold_aw) check("awvalid_held", awvalid, 1'b1);
      if (hold_w)  check("wvalid_held", wvalid, 1'b1);
      hold_ar <= arvalid && !arready;
      hold_aw <= awvalid && !awready;
      hold_w  <= wvalid && !wready;
    end
  end

  int          model_ptr = 0;
  logic [31:0] last_rdata = '0;

  function automatic int model_grant(input logic [NP-1:0] req, input int ptr);
    for (int i = 0; i < NP; i++) if (req[(ptr + i) % NP]) return (ptr + i) % NP;
    return -1;
  endfunction

  task automatic run_txn(input int p, input bit wr, input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be, input bit drop_early);
    int lat, exp_lat;
    bit seen;
    port_addr[p*AW +: AW] = a;
    port_wdata[p*32 +: 32] = d;
    port_wen[p*4 +: 4] = wr ? be : 4'h0;
    port_req[p] = 1'b1;
    exp_lat = wr ? 3 + ((aw_delay > w_delay) ? aw_delay : w_delay) + b_delay
                 : 3 + ar_delay + r_delay;
    lat = 0; seen = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      if (drop_early && lat == 1) begin
        port_req[p] = 1'b0;
        port_addr[p*AW +: AW] = ~a;
        port_wdata[p*32 +: 32] = ~d;
      end
      if (port_done != '0) seen = 1;
    end
    check("done_seen", seen, 1'b1);
    check("latency", lat, exp_lat);
    check("done_onehot", port_done, NP'(1) << p);
    port_req[p] = 1'b0;
    if (wr) begin
      check("awaddr", obs_awaddr, a);
      check("awid", obs_awid, p);
      check("wdata", obs_wdata, d);
      check("wstrb", obs_wstrb, be);
      check("wlast", obs_wlast, 1'b1);
      check("aw_hs_count", aw_hs, 1);
      check("w_hs_count", w_hs, 1);
      check("rdata_kept_on_write", port_rdata, last_rdata);
    end else begin
      check("araddr", obs_araddr, a);
      check("arid", obs_arid, p);
      check("ar_hs_count", ar_hs, 1);
      check("arvalid_cycles", arv_cycles, ar_delay + 1);
      check("port_rdata", port_rdata, r_value);
      last_rdata = r_value;
    end
    model_ptr = (p + 1) % NP;
    @(negedge clk);
    check("done_single_pulse", port_done, '0);
  endtask

  task automatic set_delays(input int ar, input int r, input int aw, input int w, input int b);
    ar_delay = ar; r_delay = r; aw_delay = aw; w_delay = w; b_delay = b;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_arvalid"}, arvalid, 1'b0);
    check({tag, "_rready"}, rready, 1'b0);
    check({tag, "_awvalid"}, awvalid, 1'b0);
    check({tag, "_wvalid"}, wvalid, 1'b0);
    check({tag, "_bready"}, bready, 1'b0);
    check({tag, "_port_done"}, port_done, '0);
  endtask

  initial begin
    int n;
    resetn = 1'b0; port_req = '0; port_wen = '0; port_addr = '0; port_wdata = '0;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    check("reset_port_rdata", port_rdata, 32'h0);
    check("reset_wlast", wlast, 1'b0);
    check("arlen", arlen, 8'd0);
    check("awsize", awsize, 3'b010);
    check("arburst", arburst, 2'b01);
    resetn = 1'b1;
    @(negedge clk);

    set_delays(0, 0, 0, 0, 0);
    r_value = 32'hDEADBEEF;
    run_txn(0, 1'b0, 32'h1FC0_0000, 32'h0, 4'h0, 1'b0);

    set_delays(0, 0, 0, 2, 0);
    run_txn(1, 1'b1, 32'h0000_0010, 32'h1234_5678, 4'b0011, 1'b0);

    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_quiet("spurious");
    end
    spurious = 1'b0;
    @(negedge clk);
    check("spurious_rdata_kept", port_rdata, last_rdata);

    set_delays(0, 0, 0, 0, 0);
    port_addr = {32'h0000_1100, 32'h0000_0100};
    port_wen = '0;
    port_req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      int g;
      r_value = $urandom;
      g = model_grant(2'b11, model_ptr);
      n = 0;
      while (port_done == '0 && n < 50) begin @(negedge clk); n++; end
      check("rr_done_onehot", port_done, NP'(1) << g);
      check("rr_arid", obs_arid, g);
      check("rr_araddr", obs_araddr, port_addr[g*AW +: AW]);
      check("rr_rdata", port_rdata, r_value);
      last_rdata = r_value;
      model_ptr = (g + 1) % NP;
      if (t == 3) port_req = '0;
      @(negedge clk);
    end

    set_delays(5, 3, 0, 0, 0);
    r_value = 32'h0BAD_F00D;
    run_txn(0, 1'b0, 32'h0000_0400, 32'h0, 4'h0, 1'b0);

    for (int k = 0; k < 16; k++) begin
      set_delays($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), $urandom_range(0, 3));
      r_value = $urandom;
      run_txn($urandom_range(0, NP - 1), 1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC,
              $urandom, 4'($urandom_range(1, 15)), 1'($urandom_range(0, 1)));
    end

    set_delays(0, 6, 0, 0, 0);
    r_value = 32'hCAFE_F00D;
    port_addr[1*AW +: AW] = 32'h0000_2000;
    port_wen = '0;
    port_req[1] = 1'b1;
    n = 0;
    while (!rready && n < 50) begin @(negedge clk); n++; end
    check("reset_mid_rd_data", rready, 1'b1);
    resetn = 1'b0;
    #1;
    check_quiet("mid_reset");
    check("mid_reset_rdata", port_rdata, 32'h0);
    port_req = '0;
    @(negedge clk);
    check_quiet("held_reset");
    resetn = 1'b1;
    last_rdata = '0;
    model_ptr = 0;
    @(negedge clk);
    check_quiet("after_reset");

    set_delays(0, 0, 0, 0, 0);
    r_value = 32'h5A5A_A5A5;
    run_txn(1, 1'b0, 32'h0000_3000, 32'h0, 4'h0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
